// File: rtl/regfile_sb.sv
// regfile_sb: NREGS x XLEN integer register file with a per-register pending-write scoreboard.
// Latency: reads are combinational (0 cycles); writes and busy updates are visible the cycle after the edge.
// Backpressure: issue_ready_o drops on a WAW hazard and ID holds the issue; `REGFILE_BYPASS_EN adds WB->read bypass.
module regfile_sb #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rs_raddr_i,
    output logic [NRD*XLEN-1:0] rs_rdata_o,
    output logic [NRD-1:0]      rs_busy_o,
    input  logic                issue_valid_i,
    input  logic [AW-1:0]       issue_rd_i,
    output logic                issue_ready_o,
    input  logic                reg_wen,
    input  logic [AW-1:0]       reg_waddr_i,
    input  logic [XLEN-1:0]     reg_wdata_i
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic             wr_fire;
    logic             issue_fire;

    assign wr_fire    = reg_wen & (reg_waddr_i != '0);
    assign issue_fire = issue_valid_i & issue_ready_o & (issue_rd_i != '0);

`ifdef REGFILE_BYPASS_EN
    // A WB in this cycle retires the current producer, so a new producer may take its place.
    assign issue_ready_o = ~busy[issue_rd_i] | (wr_fire & (reg_waddr_i == issue_rd_i));
`else
    assign issue_ready_o = ~busy[issue_rd_i] | (issue_rd_i == '0);
`endif

    // Issue is applied after WB so a same-cycle new producer leaves the register busy.
    always_comb begin
        busy_nxt = busy;
        if (wr_fire) begin
            busy_nxt[reg_waddr_i] = 1'b0;
        end
        if (issue_fire) begin
            busy_nxt[issue_rd_i] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wr_fire) begin
                regs[reg_waddr_i] <= reg_wdata_i;
            end
            busy <= busy_nxt;
        end
    end

    genvar k;
    for (k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            hit;
        logic [XLEN-1:0] data;
        logic            bsy;

        assign addr = rs_raddr_i[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        assign hit = wr_fire & (reg_waddr_i == addr);
`else
        assign hit = 1'b0;
`endif

        always_comb begin
            data = regs[addr];
            bsy  = busy[addr];
            if (hit) begin
                data = reg_wdata_i;
                bsy  = 1'b0;
            end
            // x0 and the reset window read as zero regardless of any in-flight write.
            if (!rst || addr == '0) begin
                data = '0;
                bsy  = 1'b0;
            end
        end

        assign rs_rdata_o[k*XLEN +: XLEN] = data;
        assign rs_busy_o[k]               = bsy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed checks on the default configuration plus a randomized sweep of a 32-bit, 16-entry, 4-port instance.
module tb_regfile_sb;

    logic clk;
    logic rst;

    // Default configuration: XLEN=64, NREGS=32, NRD=2
    logic [9:0]   d_raddr;
    logic [127:0] d_rdata;
    logic [1:0]   d_busy;
    logic         d_iv;
    logic [4:0]   d_ird;
    logic         d_ready;
    logic         d_wen;
    logic [4:0]   d_waddr;
    logic [63:0]  d_wdata;

    // Sweep configuration: XLEN=32, NREGS=16, NRD=4
    logic [15:0]  e_raddr;
    logic [127:0] e_rdata;
    logic [3:0]   e_busy;
    logic         e_iv;
    logic [3:0]   e_ird;
    logic         e_ready;
    logic         e_wen;
    logic [3:0]   e_waddr;
    logic [31:0]  e_wdata;

    int total;
    int bad;

    logic [31:0] m_regs [16];
    logic        m_busy [16];

    regfile_sb dut (
        .clk(clk), .rst(rst),
        .rs_raddr_i(d_raddr), .rs_rdata_o(d_rdata), .rs_busy_o(d_busy),
        .issue_valid_i(d_iv), .issue_rd_i(d_ird), .issue_ready_o(d_ready),
        .reg_wen(d_wen), .reg_waddr_i(d_waddr), .reg_wdata_i(d_wdata)
    );

    regfile_sb #(.XLEN(32), .NREGS(16), .NRD(4)) dut2 (
        .clk(clk), .rst(rst),
        .rs_raddr_i(e_raddr), .rs_rdata_o(e_rdata), .rs_busy_o(e_busy),
        .issue_valid_i(e_iv), .issue_rd_i(e_ird), .issue_ready_o(e_ready),
        .reg_wen(e_wen), .reg_waddr_i(e_waddr), .reg_wdata_i(e_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        d_raddr = '0; d_iv = 1'b0; d_ird = '0;
        d_wen = 1'b0; d_waddr = '0; d_wdata = '0;
    endtask

    initial begin
        logic [31:0] exp_d;
        logic        exp_b;
        logic        exp_rdy;
        logic [3:0]  a;

        total = 0;
        bad   = 0;
        rst   = 1'b0;
        idle();
        e_raddr = '0; e_iv = 1'b0; e_ird = '0;
        e_wen = 1'b0; e_waddr = '0; e_wdata = '0;
        for (int i = 0; i < 16; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end

        // Outputs held at zero while in reset, even with a live write request
        d_raddr = {5'd7, 5'd3};
        d_wen = 1'b1; d_waddr = 5'd3; d_wdata = 64'hFFFF;
        d_ird = 5'd3;
        #1;
        chk("rst_rdata", d_rdata, 128'h0);
        chk("rst_busy", {126'h0, d_busy}, 128'h0);
        chk("rst_ready", {127'h0, d_ready}, 128'h1);
        chk("rst_rdata2", e_rdata, 128'h0);

        @(negedge clk);
        idle();
        rst = 1'b1;

        // Write x5, issue x6, then assert reset mid-cycle
        @(negedge clk);
        d_wen = 1'b1; d_waddr = 5'd5; d_wdata = 64'h1234;
        d_iv = 1'b1; d_ird = 5'd6;
        @(negedge clk);
        idle();
        d_raddr = {5'd6, 5'd5};
        #1;
        chk("pre_rst_rdata", d_rdata, {64'h0, 64'h1234});
        chk("pre_rst_busy", {126'h0, d_busy}, 128'h2);
        d_ird = 5'd6;
        #1;
        chk("pre_rst_ready", {127'h0, d_ready}, 128'h0);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_rdata", d_rdata, 128'h0);
        chk("mid_rst_busy", {126'h0, d_busy}, 128'h0);
        chk("mid_rst_ready", {127'h0, d_ready}, 128'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_rdata", d_rdata, 128'h0);
        chk("post_rst_busy", {126'h0, d_busy}, 128'h0);

        // Basic write / read on both ports
        @(negedge clk);
        idle();
        d_wen = 1'b1; d_waddr = 5'd3; d_wdata = 64'hDEADBEEF_00000001;
        @(negedge clk);
        idle();
        d_raddr = {5'd3, 5'd3};
        #1;
        chk("wr_rd_both", d_rdata, {64'hDEADBEEF_00000001, 64'hDEADBEEF_00000001});

        // Write to x0 is dropped
        @(negedge clk);
        idle();
        d_wen = 1'b1; d_waddr = 5'd0; d_wdata = '1;
        d_iv = 1'b1; d_ird = 5'd0;
        d_raddr = {5'd0, 5'd0};
        #1;
        chk("x0_same_cycle", d_rdata, 128'h0);
        chk("x0_ready", {127'h0, d_ready}, 128'h1);
        @(negedge clk);
        idle();
        d_raddr = {5'd0, 5'd3};
        #1;
        chk("x0_after", d_rdata, {64'h0, 64'hDEADBEEF_00000001});
        chk("x0_busy", {126'h0, d_busy}, 128'h0);

        // RAW: issue x7, then WB x7
        @(negedge clk);
        idle();
        d_iv = 1'b1; d_ird = 5'd7;
        #1;
        chk("raw_issue_ready", {127'h0, d_ready}, 128'h1);
        @(negedge clk);
        idle();
        d_raddr = {5'd7, 5'd7};
        #1;
        chk("raw_busy", {126'h0, d_busy}, 128'h3);
        d_wen = 1'b1; d_waddr = 5'd7; d_wdata = 64'h55;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("raw_wb_busy", {126'h0, d_busy}, 128'h0);
        chk("raw_wb_data", d_rdata, {64'h55, 64'h55});
`else
        chk("raw_wb_busy", {126'h0, d_busy}, 128'h3);
        chk("raw_wb_data", d_rdata, 128'h0);
`endif
        @(negedge clk);
        idle();
        d_raddr = {5'd7, 5'd7};
        #1;
        chk("raw_after_busy", {126'h0, d_busy}, 128'h0);
        chk("raw_after_data", d_rdata, {64'h55, 64'h55});

        // WAW: x9 busy, second issue blocked, then issue alongside WB
        @(negedge clk);
        idle();
        d_iv = 1'b1; d_ird = 5'd9;
        @(negedge clk);
        idle();
        d_iv = 1'b1; d_ird = 5'd9;
        #1;
        chk("waw_blocked", {127'h0, d_ready}, 128'h0);
        @(negedge clk);
        idle();
        d_raddr = {5'd0, 5'd9};
        #1;
        chk("waw_still_busy", {126'h0, d_busy}, 128'h1);
        d_iv = 1'b1; d_ird = 5'd9;
        d_wen = 1'b1; d_waddr = 5'd9; d_wdata = 64'hABC;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("waw_wb_ready", {127'h0, d_ready}, 128'h1);
`else
        chk("waw_wb_ready", {127'h0, d_ready}, 128'h0);
`endif
        @(negedge clk);
        idle();
        d_raddr = {5'd0, 5'd9};
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("waw_after_busy", {126'h0, d_busy}, 128'h1);
`else
        chk("waw_after_busy", {126'h0, d_busy}, 128'h0);
`endif
        chk("waw_after_data", d_rdata, {64'h0, 64'hABC});

        // Randomized sweep against the reference model
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            e_wen   = 1'($urandom_range(0, 1));
            e_waddr = 4'($urandom_range(0, 15));
            e_wdata = $urandom;
            e_iv    = 1'($urandom_range(0, 1));
            e_ird   = 4'($urandom_range(0, 15));
            for (int k = 0; k < 4; k++) begin
                e_raddr[k*4 +: 4] = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 3) == 0) e_raddr[3:0] = e_waddr;
            if ($urandom_range(0, 3) == 0) e_ird = e_waddr;
            #1;
            for (int k = 0; k < 4; k++) begin
                a = e_raddr[k*4 +: 4];
                if (a == 4'd0) begin
                    exp_d = '0; exp_b = 1'b0;
                end else begin
                    exp_d = m_regs[a]; exp_b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
                    if (e_wen && e_waddr == a) begin
                        exp_d = e_wdata; exp_b = 1'b0;
                    end
`endif
                end
                chk("sweep_rdata", {96'h0, e_rdata[k*32 +: 32]}, {96'h0, exp_d});
                chk("sweep_busy", {127'h0, e_busy[k]}, {127'h0, exp_b});
            end
`ifdef REGFILE_BYPASS_EN
            exp_rdy = !m_busy[e_ird] || (e_wen && e_waddr == e_ird && e_ird != 4'd0);
`else
            exp_rdy = !m_busy[e_ird] || (e_ird == 4'd0);
`endif
            chk("sweep_ready", {127'h0, e_ready}, {127'h0, exp_rdy});
            @(posedge clk);
            if (e_wen && e_waddr != 4'd0) begin
                m_regs[e_waddr] = e_wdata;
                m_busy[e_waddr] = 1'b0;
            end
            if (e_iv && exp_rdy && e_ird != 4'd0) begin
                m_busy[e_ird] = 1'b1;
            end
        end

        @(negedge clk);
        e_wen = 1'b0; e_iv = 1'b0; e_raddr = '0;
        #1;
        chk("sweep_x0_end", {124'h0, e_busy}, 128'h0);
        chk("sweep_x0_data", e_rdata, 128'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with an integrated per-register scoreboard for the pipelined RV64 core. It sits between ID (read ports and issue) and WB (write port). It provides NRD combinational read ports, one clocked write port and pending-write tracking. Optional same-cycle write-to-read bypass is compiled in or out. ID uses the busy and ready outputs to stall on RAW and WAW hazards.

## Interface
Parameters:
- XLEN, 64, register width in bits
- NREGS, 32, number of architectural registers; must be a power of two ≥ 2; register 0 is hardwired zero
- NRD, 2, number of read ports, 1..4
- AW, $clog2(NREGS), register address width (derived; not overridden)

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- rs_raddr_i  in  NRD*AW  read addresses; port k occupies bits [k*AW +: AW]
- rs_rdata_o  out  NRD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN]
- rs_busy_o  out  NRD  port k's register has a pending write; ID must stall
- issue_valid_i  in  1  ID issues an instruction that writes issue_rd_i
- issue_rd_i  in  AW  destination register of the issuing instruction
- issue_ready_o  out  1  issue_rd_i may be marked busy this cycle (no WAW hazard)
- reg_wen  in  1  WB write enable
- reg_waddr_i  in  AW  WB destination register
- reg_wdata_i  in  XLEN  WB write data

## Operation
- State: regs[NREGS] (XLEN bits each) and busy[NREGS] (1 bit each).
- While rst=0: every regs entry and every busy bit is 0. rs_rdata_o is all 0, rs_busy_o is all 0, issue_ready_o=1.
- Write path:
  - On a clk edge with reg_wen=1 and reg_waddr_i≠0: regs[reg_waddr_i] ← reg_wdata_i and busy[reg_waddr_i] ← 0.
  - A write to address 0 is dropped.
  - A write to a register that is not busy is still performed; busy stays 0.
- Issue path:
  - On a clk edge with issue_valid_i=1, issue_ready_o=1 and issue_rd_i≠0: busy[issue_rd_i] ← 1.
  - Issue with issue_ready_o=0 is ignored. ID must hold the instruction.
  - issue_rd_i=0 never sets busy.
- Simultaneous issue and WB to the same register: data is written and busy ends at 1, because the new producer wins.
- Read, port k, with address a:
  - a=0: data 0, busy 0.
  - Otherwise: data = regs[a], busy = busy[a], unless the bypass rule applies (see Configuration).
- Read ports are independent. Any number of ports may read the same address.
- Register 0 is never stored as nonzero and never reported busy, whatever the stimulus.

## Timing
- Reads are purely combinational with zero latency; no read enable.
- Writes and busy-bit updates become visible at the outputs in the cycle after the capturing edge. The bypass is the only exception.
- issue_ready_o is combinational from issue_rd_i, busy, reg_wen and reg_waddr_i.
- Reset is asynchronous:
  - Asserting rst mid-operation clears all state immediately, including in-flight busy bits.
  - Deassertion is sampled by the next rising edge. The first issue or write can take effect on the first edge with rst=1.
- Every output is a defined function of the inputs and state in every cycle; no X after reset.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined (bypass enabled):
  - When reg_wen=1, reg_waddr_i=a≠0 and port k reads a: rs_rdata_o[k] = reg_wdata_i and rs_busy_o[k] = 0 in the same cycle.
  - issue_ready_o = ~busy[issue_rd_i] | (reg_wen & reg_waddr_i==issue_rd_i & issue_rd_i≠0).
- Undefined (bypass disabled):
  - Reads return stored state only. rs_busy_o stays 1 during the WB cycle and clears the cycle after.
  - issue_ready_o = ~busy[issue_rd_i] | (issue_rd_i==0).
- Sequential state and write behaviour are identical in both builds.

## Test plan
- Reset: write x5=0x1234 and issue x6, then pulse rst=0 mid-cycle → all reads return 0 and rs_busy_o=0 immediately, issue_ready_o=1.
- Basic write/read, NRD=2:
  - Stimulus: WB writes x3=0xDEADBEEF_00000001.
  - Required, next cycle: ports 0 and 1 both reading x3 return that value.
  - Required: a write to x0 leaves x0 reading 0.
- RAW scoreboard: issue x7 → next cycle rs_busy_o=1 for any port reading x7. Then WB x7=0x55:
  - Bypass build: that cycle shows busy=0 and data 0x55.
  - Non-bypass build: that cycle still shows busy=1 with old data; the next cycle shows busy=0 and data 0x55.
- WAW:
  - With x9 busy, issue x9 with no WB → issue_ready_o=0 and busy remains set.
  - Same-cycle WB x9 (bypass build) → issue_ready_o=1, and after the edge busy[9]=1 and regs[9] holds the WB data.
- Parameter sweep, XLEN=32, NREGS=16, NRD=4: random issue/WB/read traffic against a reference model for 10k cycles → zero mismatches, and x0 always reads 0, not busy.
